// File: rtl/rps_draw_sequencer.sv
// rtl/rps_draw_sequencer.sv - two-panel image redraw sequencer feeding the 160x120 VGA plot port
module rps_draw_sequencer #(
    parameter int PANEL_W = 80,
    parameter int PANEL_H = 120,
    parameter int ROM_LAT = 1
) (
    input  logic        CLOCK_50,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  choice_c,
    input  logic [1:0]  choice_u,
    output logic [14:0] rom_addr,
    output logic [1:0]  rom_sel,
    input  logic        rom_q,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [2:0]  colour,
    output logic        plot,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE,
        SCAN_C,
        GAP,
        SCAN_U,
        DRAIN,
        DONE
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [6:0]  x_local;
    logic [6:0]  y_local;
    logic [1:0]  sel_u;
    logic [1:0]  lat_cnt;
    logic        issue;
    logic        last_pix;
    logic        lat_done;

    // Coordinates, panel id and valid travel alongside the ROM read so they
    // emerge in the same cycle as the matching rom_q.
    logic [6:0]  x_pipe     [ROM_LAT];
    logic [6:0]  y_pipe     [ROM_LAT];
    logic        panel_pipe [ROM_LAT];
    logic        valid_pipe [ROM_LAT];

    // Choice 11 shares the paper image with 10.
    function automatic logic [1:0] fold_choice(input logic [1:0] c);
        return (c == 2'b11) ? 2'b10 : c;
    endfunction

    assign issue    = (state == SCAN_C) || (state == SCAN_U);
    assign last_pix = (x_local == 7'(PANEL_W - 1)) && (y_local == 7'(PANEL_H - 1));
    assign lat_done = (lat_cnt == 2'(ROM_LAT - 1));

    // State register; reset drops straight back to IDLE.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and status flags.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = SCAN_C;
                end
            end
            SCAN_C: begin
                busy = 1'b1;
                if (last_pix) begin
                    state_next = GAP;
                end
            end
            GAP: begin
                busy = 1'b1;
                if (lat_done) begin
                    state_next = SCAN_U;
                end
            end
            SCAN_U: begin
                busy = 1'b1;
                if (last_pix) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (lat_done) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Latch both choices on accept; swap the image select only once the
    // computer panel's last read has left the ROM pipeline.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            rom_sel <= 2'b00;
            sel_u   <= 2'b00;
        end else if (state == IDLE && start) begin
            rom_sel <= fold_choice(choice_c);
            sel_u   <= fold_choice(choice_u);
        end else if (state == GAP && lat_done) begin
            rom_sel <= sel_u;
        end
    end

    // Raster scan counters; rom_addr runs alongside so no multiply is needed.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            x_local  <= 7'd0;
            y_local  <= 7'd0;
            rom_addr <= 15'd0;
        end else if (issue) begin
            if (last_pix) begin
                x_local  <= 7'd0;
                y_local  <= 7'd0;
                rom_addr <= 15'd0;
            end else begin
                rom_addr <= rom_addr + 15'd1;
                if (x_local == 7'(PANEL_W - 1)) begin
                    x_local <= 7'd0;
                    y_local <= y_local + 7'd1;
                end else begin
                    x_local <= x_local + 7'd1;
                end
            end
        end
    end

    // Counts the flush cycles spent in GAP and DRAIN.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            lat_cnt <= 2'd0;
        end else if (state == GAP || state == DRAIN) begin
            lat_cnt <= lat_done ? 2'd0 : lat_cnt + 2'd1;
        end else begin
            lat_cnt <= 2'd0;
        end
    end

    // Delay line matching the ROM read latency.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ROM_LAT; i++) begin
                x_pipe[i]     <= 7'd0;
                y_pipe[i]     <= 7'd0;
                panel_pipe[i] <= 1'b0;
                valid_pipe[i] <= 1'b0;
            end
        end else begin
            x_pipe[0]     <= x_local;
            y_pipe[0]     <= y_local;
            panel_pipe[0] <= (state == SCAN_U);
            valid_pipe[0] <= issue;
            for (int i = 1; i < ROM_LAT; i++) begin
                x_pipe[i]     <= x_pipe[i-1];
                y_pipe[i]     <= y_pipe[i-1];
                panel_pipe[i] <= panel_pipe[i-1];
                valid_pipe[i] <= valid_pipe[i-1];
            end
        end
    end

    assign plot   = valid_pipe[ROM_LAT-1];
    assign y      = y_pipe[ROM_LAT-1];
    assign x      = {1'b0, x_pipe[ROM_LAT-1]} + (panel_pipe[ROM_LAT-1] ? 8'(PANEL_W) : 8'd0);
    assign colour = !plot                  ? 3'b000 :
                    !rom_q                 ? 3'b010 :
                    panel_pipe[ROM_LAT-1]  ? 3'b000 : 3'b111;

endmodule

// File: tb/tb_rps_draw_sequencer.sv
// tb/tb_rps_draw_sequencer.sv - randomized self-checking bench for rps_draw_sequencer
module tb_rps_draw_sequencer;

    logic        CLOCK_50 = 1'b0;
    logic        reset_n  = 1'b0;
    logic        start1   = 1'b0;
    logic        start2   = 1'b0;
    logic [1:0]  choice_c = 2'b00;
    logic [1:0]  choice_u = 2'b00;
    logic        rom_q1   = 1'b0;
    logic        rom_q2   = 1'b0;
    logic        rom_q2a  = 1'b0;
    logic        sel2     = 1'b0;

    logic [14:0] rom_addr1, rom_addr2;
    logic [1:0]  rom_sel1, rom_sel2;
    logic [7:0]  x1, x2;
    logic [6:0]  y1, y2;
    logic [2:0]  colour1, colour2;
    logic        plot1, plot2, busy1, busy2, done1, done2;

    logic [14:0] o_addr;
    logic [1:0]  o_sel;
    logic [7:0]  o_x;
    logic [6:0]  o_y;
    logic [2:0]  o_colour;
    logic        o_plot, o_busy, o_done;

    int vectors     = 0;
    int miscompares = 0;
    bit mem [3][9600];

    rps_draw_sequencer #(.PANEL_W(80), .PANEL_H(120), .ROM_LAT(1)) dut1 (
        .CLOCK_50(CLOCK_50), .reset_n(reset_n), .start(start1),
        .choice_c(choice_c), .choice_u(choice_u),
        .rom_addr(rom_addr1), .rom_sel(rom_sel1), .rom_q(rom_q1),
        .x(x1), .y(y1), .colour(colour1), .plot(plot1), .busy(busy1), .done(done1)
    );

    rps_draw_sequencer #(.PANEL_W(80), .PANEL_H(120), .ROM_LAT(2)) dut2 (
        .CLOCK_50(CLOCK_50), .reset_n(reset_n), .start(start2),
        .choice_c(choice_c), .choice_u(choice_u),
        .rom_addr(rom_addr2), .rom_sel(rom_sel2), .rom_q(rom_q2),
        .x(x2), .y(y2), .colour(colour2), .plot(plot2), .busy(busy2), .done(done2)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    assign o_addr   = sel2 ? rom_addr2 : rom_addr1;
    assign o_sel    = sel2 ? rom_sel2  : rom_sel1;
    assign o_x      = sel2 ? x2        : x1;
    assign o_y      = sel2 ? y2        : y1;
    assign o_colour = sel2 ? colour2   : colour1;
    assign o_plot   = sel2 ? plot2     : plot1;
    assign o_busy   = sel2 ? busy2     : busy1;
    assign o_done   = sel2 ? done2     : done1;

    function automatic logic rd(input logic [1:0] s, input logic [14:0] a);
        if (s == 2'b11 || a >= 15'd9600) return 1'b0;
        return mem[s][a];
    endfunction

    function automatic logic [1:0] fold(input logic [1:0] c);
        return (c == 2'b11) ? 2'b10 : c;
    endfunction

    // Synchronous image ROMs behind the external mux, latency 1 and 2.
    always @(posedge CLOCK_50) begin
        rom_q1  <= rd(rom_sel1, rom_addr1);
        rom_q2a <= rd(rom_sel2, rom_addr2);
        rom_q2  <= rom_q2a;
    end

    task automatic fill_rom(input bit parity);
        for (int s = 0; s < 3; s++)
            for (int a = 0; a < 9600; a++)
                mem[s][a] = parity ? a[0] : 1'($urandom);
    endtask

    task automatic run_redraw(input logic [1:0] cc, input logic [1:0] cu, input int lat,
                              input int disturb_at, input int abort_at, input bit start_in_done);
        int plots = 0;
        int dones = 0;
        int last  = 19201 + 2 * lat;
        int p;
        bit ep, eb, ed, ei, is_u;
        logic [7:0]  ex;
        logic [6:0]  ey;
        logic [2:0]  ecol;
        logic [14:0] ea;
        logic [1:0]  es;
        logic [1:0]  sc = fold(cc);
        logic [1:0]  su = fold(cu);
        choice_c = cc;
        choice_u = cu;
        sel2 = (lat == 2);
        if (lat == 2) start2 = 1'b1; else start1 = 1'b1;
        for (int n = 1; n <= last + 3; n++) begin
            @(posedge CLOCK_50);
            #1;
            start1 = 1'b0;
            start2 = 1'b0;
            if (n == abort_at) begin
                reset_n = 1'b0;
                #1;
                vectors += 3;
                if (o_plot !== 1'b0) begin miscompares++; $display("FAIL reset_plot n=%0d got=%0b exp=0", n, o_plot); end
                if (o_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy n=%0d got=%0b exp=0", n, o_busy); end
                if (o_colour !== 3'b000) begin miscompares++; $display("FAIL reset_colour n=%0d got=%0b exp=000", n, o_colour); end
                return;
            end
            eb = (n >= 1) && (n <= 19200 + 2 * lat);
            ed = (n == last);
            ep = 1'b0; is_u = 1'b0; p = 0;
            if (n >= 1 + lat && n <= 9600 + lat) begin
                ep = 1'b1; p = n - 1 - lat;
            end else if (n >= 9601 + 2 * lat && n <= 19200 + 2 * lat) begin
                ep = 1'b1; is_u = 1'b1; p = n - 9601 - 2 * lat;
            end
            ex   = 8'((is_u ? 80 : 0) + p % 80);
            ey   = 7'(p / 80);
            ecol = mem[is_u ? su : sc][p] ? (is_u ? 3'b000 : 3'b111) : 3'b010;
            ei = 1'b0; ea = 15'd0;
            if (n >= 1 && n <= 9600) begin
                ei = 1'b1; ea = 15'(n - 1);
            end else if (n >= 9601 + lat && n <= 19200 + lat) begin
                ei = 1'b1; ea = 15'(n - 9601 - lat);
            end
            es = (n <= 9600 + lat) ? sc : su;

            vectors += 3;
            if (o_plot !== ep) begin miscompares++; $display("FAIL plot n=%0d got=%0b exp=%0b", n, o_plot, ep); end
            if (o_busy !== eb) begin miscompares++; $display("FAIL busy n=%0d got=%0b exp=%0b", n, o_busy, eb); end
            if (o_done !== ed) begin miscompares++; $display("FAIL done n=%0d got=%0b exp=%0b", n, o_done, ed); end
            if (ep) begin
                vectors += 3;
                if (o_x !== ex) begin miscompares++; $display("FAIL x n=%0d got=%0d exp=%0d", n, o_x, ex); end
                if (o_y !== ey) begin miscompares++; $display("FAIL y n=%0d got=%0d exp=%0d", n, o_y, ey); end
                if (o_colour !== ecol) begin miscompares++; $display("FAIL colour n=%0d got=%0b exp=%0b", n, o_colour, ecol); end
            end
            if (ei) begin
                vectors++;
                if (o_addr !== ea) begin miscompares++; $display("FAIL rom_addr n=%0d got=%0d exp=%0d", n, o_addr, ea); end
            end
            if (eb) begin
                vectors++;
                if (o_sel !== es) begin miscompares++; $display("FAIL rom_sel n=%0d got=%0b exp=%0b", n, o_sel, es); end
            end
            if (o_plot === 1'b1) plots++;
            if (o_done === 1'b1) dones++;
            if (n == disturb_at) begin
                if (lat == 2) start2 = 1'b1; else start1 = 1'b1;
                choice_c = 2'b01;
                choice_u = 2'b01;
            end
            if (start_in_done && n == last) begin
                if (lat == 2) start2 = 1'b1; else start1 = 1'b1;
            end
        end
        vectors += 2;
        if (plots != 19200) begin miscompares++; $display("FAIL plot_count got=%0d exp=19200", plots); end
        if (dones != 1) begin miscompares++; $display("FAIL done_count got=%0d exp=1", dones); end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (5) @(posedge CLOCK_50);
        #1;
        vectors += 10;
        if (rom_addr1 !== 15'd0) begin miscompares++; $display("FAIL rst_rom_addr got=%0d exp=0", rom_addr1); end
        if (rom_sel1 !== 2'b00) begin miscompares++; $display("FAIL rst_rom_sel got=%0b exp=00", rom_sel1); end
        if (x1 !== 8'd0) begin miscompares++; $display("FAIL rst_x got=%0d exp=0", x1); end
        if (y1 !== 7'd0) begin miscompares++; $display("FAIL rst_y got=%0d exp=0", y1); end
        if (colour1 !== 3'b000) begin miscompares++; $display("FAIL rst_colour got=%0b exp=000", colour1); end
        if (plot1 !== 1'b0) begin miscompares++; $display("FAIL rst_plot got=%0b exp=0", plot1); end
        if (busy1 !== 1'b0) begin miscompares++; $display("FAIL rst_busy got=%0b exp=0", busy1); end
        if (done1 !== 1'b0) begin miscompares++; $display("FAIL rst_done got=%0b exp=0", done1); end
        if (plot2 !== 1'b0) begin miscompares++; $display("FAIL rst_plot2 got=%0b exp=0", plot2); end
        if (busy2 !== 1'b0) begin miscompares++; $display("FAIL rst_busy2 got=%0b exp=0", busy2); end
        reset_n = 1'b1;
        repeat (3) @(posedge CLOCK_50);
        #1;
        vectors += 3;
        if (busy1 !== 1'b0) begin miscompares++; $display("FAIL idle_busy got=%0b exp=0", busy1); end
        if (plot1 !== 1'b0) begin miscompares++; $display("FAIL idle_plot got=%0b exp=0", plot1); end
        if (busy2 !== 1'b0) begin miscompares++; $display("FAIL idle_busy2 got=%0b exp=0", busy2); end
    endtask

    task automatic test_full_redraw();
        fill_rom(1'b0);
        run_redraw(2'b00, 2'b10, 1, 0, 0, 1'b0);
    endtask

    task automatic test_colour_and_ignore_busy();
        fill_rom(1'b1);
        run_redraw(2'b00, 2'b10, 1, 5000, 0, 1'b0);
    endtask

    task automatic test_reset_mid_draw();
        logic [1:0] cc = 2'($urandom_range(0, 3));
        logic [1:0] cu = 2'($urandom_range(0, 3));
        fill_rom(1'b0);
        run_redraw(cc, cu, 1, 0, 5000, 1'b0);
        repeat (2) @(posedge CLOCK_50);
        #1;
        reset_n = 1'b1;
        @(posedge CLOCK_50);
        #1;
        vectors += 2;
        if (plot1 !== 1'b0) begin miscompares++; $display("FAIL post_rst_plot got=%0b exp=0", plot1); end
        if (busy1 !== 1'b0) begin miscompares++; $display("FAIL post_rst_busy got=%0b exp=0", busy1); end
        run_redraw(cu, cc, 1, 0, 0, 1'b0);
    endtask

    task automatic test_encoding11_lat2();
        fill_rom(1'b0);
        run_redraw(2'b11, 2'($urandom_range(0, 3)), 2, 0, 0, 1'b1);
    endtask

    initial begin
        #(20 * 99000);
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_full_redraw();
        test_colour_and_ignore_busy();
        test_reset_mid_draw();
        test_encoding11_lat2();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
